arb_grant_dispatcher: RTL and testbench

Requester-side companion to `rotating_priority_arbiter` that turns its index grant into a complete data transfer. It gathers `NUM_REQUESTS` valid/ready request channels and drives the arbiter's `req` vector, gating it when there is no space. It consumes `gnt`/`gnt_valid` in the same cycle, returns a one-hot accept to the winning requester, and queues that requester's payload and source id in a 2-entry output buffer. The buffer drains to a single shared downstream consumer over valid/ready.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/arb_grant_dispatcher_if.sv | 39 +++
 rtl/arb_out_fifo.sv | 73 +++++++
 rtl/arb_grant_dispatcher.sv | 92 +++++++++
 tb/tb_arb_grant_dispatcher.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and helpers for the grant dispatcher
//
// Purpose : output buffer depth, count width and the one-hot helper that
//           turns a grant index into the requester accept vector.
// Ports   : none (package).
package arb_pkg;

   // The dispatcher's output buffer holds exactly two entries; its 1-bit
   // head/tail pointers rely on this.
   localparam int ARB_BUF_DEPTH = 2;
   localparam int ARB_CNT_W     = $clog2(ARB_BUF_DEPTH + 1);

   // Widest requester vector the one-hot helper can produce; callers cast
   // the result down to their own NUM_REQUESTS width.
   localparam int ARB_MAX_REQ = 64;

   typedef logic [ARB_MAX_REQ-1:0] arb_vec_t;

   function automatic arb_vec_t onehot(input int unsigned idx);
      return arb_vec_t'(1) << idx;
   endfunction

endpackage

// File: rtl/arb_grant_dispatcher_if.sv
// rtl/arb_grant_dispatcher_if.sv - request, arbiter and output bundle for the dispatcher
//
// Purpose : groups the requester channels, the arbiter req/grant pair, the
//           downstream valid/ready channel and the error flag.
// Modports: slave  - dispatcher view (consumes requests/grants, drives output)
//           master - environment view (requesters, arbiter and consumer)
// Signals : req_valid/req_data/req_ready  requester channels
//           arb_req/arb_gnt/arb_gnt_valid  arbiter connection
//           out_valid/out_data/out_src/out_ready  downstream channel
//           err_bad_gnt  sticky protocol error
interface arb_grant_dispatcher_if #(
   parameter int NUM_REQUESTS = 4,
   parameter int DATA_WIDTH   = 32
);
   localparam int IDX_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

   logic [NUM_REQUESTS-1:0]            req_valid;
   logic [NUM_REQUESTS*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQUESTS-1:0]            req_ready;
   logic [NUM_REQUESTS-1:0]            arb_req;
   logic [IDX_W-1:0]                   arb_gnt;
   logic                               arb_gnt_valid;
   logic                               out_valid;
   logic [DATA_WIDTH-1:0]              out_data;
   logic [IDX_W-1:0]                   out_src;
   logic                               out_ready;
   logic                               err_bad_gnt;

   modport slave (
      input  req_valid, req_data, arb_gnt, arb_gnt_valid, out_ready,
      output req_ready, arb_req, out_valid, out_data, out_src, err_bad_gnt
   );

   modport master (
      output req_valid, req_data, arb_gnt, arb_gnt_valid, out_ready,
      input  req_ready, arb_req, out_valid, out_data, out_src, err_bad_gnt
   );

endinterface

// File: rtl/arb_out_fifo.sv
// rtl/arb_out_fifo.sv - generic 2-entry circular buffer
//
// Purpose : holds accepted {payload, source} entries in FIFO order.
// Ports   : clk, rst        clock, synchronous active-high reset
//           wr_en, wr_data  push (ignored while full)
//           rd_en           pop of the head entry (ignored while empty)
//           rd_data         head entry, straight from storage
//           count           number of valid entries (0..2)
module arb_out_fifo
   import arb_pkg::*;
#(
   parameter int WIDTH = 34
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 rd_en,
   output logic [WIDTH-1:0]     rd_data,
   output logic [ARB_CNT_W-1:0] count
);

   localparam logic [ARB_CNT_W-1:0] CNT_FULL = ARB_CNT_W'(ARB_BUF_DEPTH);

   logic [WIDTH-1:0]     mem_q [ARB_BUF_DEPTH];
   logic [WIDTH-1:0]     mem_d [ARB_BUF_DEPTH];
   logic                 head_q, head_d;
   logic                 tail_q, tail_d;
   logic [ARB_CNT_W-1:0] count_q, count_d;
   logic                 do_wr;
   logic                 do_rd;

   assign do_wr = wr_en & (count_q != CNT_FULL);
   assign do_rd = rd_en & (count_q != '0);

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_wr) begin
         mem_d[tail_q] = wr_data;
         tail_d        = ~tail_q;
      end
      if (do_rd) begin
         head_d = ~head_q;
      end
      // Push and pop together leave the occupancy unchanged.
      unique case ({do_wr, do_rd})
         2'b10:   count_d = count_q + ARB_CNT_W'(1);
         2'b01:   count_d = count_q - ARB_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign rd_data = mem_q[head_q];
   assign count   = count_q;

endmodule

// File: rtl/arb_grant_dispatcher.sv
// rtl/arb_grant_dispatcher.sv - turns arbiter index grants into buffered transfers
//
// Purpose : gates the arbiter request vector on buffer space, accepts the
//           granted requester in the grant cycle, buffers its payload and
//           id, and drains the buffer to one downstream consumer.
// Ports   : clk  clock, rising edge
//           rst  synchronous active-high reset
//           bus  arb_grant_dispatcher_if.slave (requests, arbiter, output,
//                sticky err_bad_gnt)
module arb_grant_dispatcher
   import arb_pkg::*;
#(
   parameter int NUM_REQUESTS = 4,
   parameter int DATA_WIDTH   = 32
) (
   input logic                   clk,
   input logic                   rst,
   arb_grant_dispatcher_if.slave bus
);

   localparam int IDX_W   = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
   localparam int ENTRY_W = DATA_WIDTH + IDX_W;
   localparam logic [ARB_CNT_W-1:0] CNT_FULL = ARB_CNT_W'(ARB_BUF_DEPTH);

   logic [ARB_CNT_W-1:0]  fifo_count;
   logic [ENTRY_W-1:0]    fifo_wr_data;
   logic [ENTRY_W-1:0]    fifo_rd_data;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic                  gnt_req_valid;
   logic                  space;
   logic                  accept;
   logic                  bad_gnt;
   logic                  out_valid_w;
   logic                  pop;
   logic                  err_q, err_d;

   // Select the granted requester's payload and valid. An index with no
   // matching requester (possible when NUM_REQUESTS is not a power of two)
   // selects nothing, so it reads as an invalid requester and becomes a
   // bad grant below.
   always_comb begin
      gnt_data      = '0;
      gnt_req_valid = 1'b0;
      for (int i = 0; i < NUM_REQUESTS; i++) begin
         if (bus.arb_gnt == IDX_W'(i)) begin
            gnt_data      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            gnt_req_valid = bus.req_valid[i];
         end
      end
   end

   assign space       = (fifo_count != CNT_FULL);
   assign accept      = bus.arb_gnt_valid & space & gnt_req_valid;
   assign bad_gnt     = bus.arb_gnt_valid & ~accept;
   assign out_valid_w = (fifo_count != '0);
   assign pop         = out_valid_w & bus.out_ready;

   // Withholding requests while full stops the arbiter from rotating its
   // priority on grants that could not be taken.
   assign bus.arb_req   = space ? bus.req_valid : '0;
   assign bus.req_ready = accept ? NUM_REQUESTS'(onehot(32'(bus.arb_gnt))) : '0;

   assign fifo_wr_data = {gnt_data, bus.arb_gnt};

   arb_out_fifo #(
      .WIDTH (ENTRY_W)
   ) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_data (fifo_wr_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count)
   );

   assign err_d = err_q | bad_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.out_valid   = out_valid_w;
   assign bus.out_data    = fifo_rd_data[ENTRY_W-1:IDX_W];
   assign bus.out_src     = fifo_rd_data[IDX_W-1:0];
   assign bus.err_bad_gnt = err_q;

endmodule

// File: tb/tb_arb_grant_dispatcher.sv
// tb/tb_arb_grant_dispatcher.sv - scoreboard bench for arb_grant_dispatcher
module tb_arb_grant_dispatcher;

   localparam int N  = 4;
   localparam int DW = 32;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    src;
   } ent_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   arb_grant_dispatcher_if #(.NUM_REQUESTS(N), .DATA_WIDTH(DW)) bus ();

   arb_grant_dispatcher #(.NUM_REQUESTS(N), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   ent_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   err_exp  = 1'b0;
   bit   mon_en   = 1'b0;
   bit   just_reset = 1'b0;
   bit   pend_push, pend_bad, pend_rst;
   ent_t pend_ent;
   int   rr_last = N - 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Apply the previous cycle's model effects at the clock edge.
   task automatic commit();
      if (pend_rst) begin
         sb_q.delete();
         err_exp    = 1'b0;
         mon_en     = 1'b1;
         just_reset = 1'b1;
      end else begin
         just_reset = 1'b0;
         if (pend_push) sb_q.push_back(pend_ent);
         if (pend_bad) err_exp = 1'b1;
      end
      pend_push = 1'b0;
      pend_bad  = 1'b0;
      pend_rst  = 1'b0;
   endtask

   // One clock cycle of stimulus. With use_arb the grant comes from a
   // rotating-priority arbiter model fed by the expected arb_req.
   task automatic step(input bit r, input logic [3:0] rv, input int g, input bit gv,
                       input bit ordy, input bit use_arb = 1'b0);
      logic [DW-1:0] d [N];
      bit            space, acc;
      logic [3:0]    exp_rdy, exp_arb;
      int            gg;
      bit            gvv;
      @(posedge clk);
      commit();
      #1;
      space   = (sb_q.size() < 2);
      exp_arb = space ? rv : 4'b0000;
      gg  = g;
      gvv = gv;
      if (use_arb) begin
         gvv = 1'b0;
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (rr_last + k) % N;
            if (!gvv && exp_arb[idx]) begin
               gg      = idx;
               gvv     = 1'b1;
               rr_last = idx;
            end
         end
      end
      rst               = r;
      bus.req_valid     = rv;
      for (int i = 0; i < N; i++) begin
         d[i] = $urandom;
         bus.req_data[i*DW +: DW] = d[i];
      end
      bus.arb_gnt       = 2'(gg);
      bus.arb_gnt_valid = gvv;
      bus.out_ready     = ordy;
      acc     = gvv && space && rv[gg];
      exp_rdy = acc ? 4'(1 << gg) : 4'b0000;
      #1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("arb_req", 64'(bus.arb_req), 64'(exp_arb));
      pend_push = acc;
      pend_ent  = '{data: d[gg], src: 2'(gg)};
      pend_bad  = gvv && !acc;
      pend_rst  = r;
   endtask

   // Monitor: compares the head of the expected queue whenever the DUT
   // presents an output, and pops it on a handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(sb_q.size() != 0));
            chk("err_bad_gnt", 64'(bus.err_bad_gnt), 64'(err_exp));
            if (sb_q.size() != 0) begin
               chk("out_data", 64'(bus.out_data), 64'(sb_q[0].data));
               chk("out_src", 64'(bus.out_src), 64'(sb_q[0].src));
               if (bus.out_ready) void'(sb_q.pop_front());
            end else if (just_reset) begin
               chk("reset_out_data", 64'(bus.out_data), 64'd0);
               chk("reset_out_src", 64'(bus.out_src), 64'd0);
            end
         end
      end
   end

   initial begin
      logic [3:0] rv;
      int         g;
      rst               = 1'b1;
      bus.req_valid     = '0;
      bus.req_data      = '0;
      bus.arb_gnt       = '0;
      bus.arb_gnt_valid = 1'b0;
      bus.out_ready     = 1'b0;
      pend_push = 1'b0; pend_bad = 1'b0; pend_rst = 1'b0;

      step(1, 4'b0000, 0, 0, 1);
      step(1, 4'b0000, 0, 0, 1);

      // Single transfer, visible the following cycle.
      step(0, 4'b0100, 2, 1, 1);
      step(0, 4'b0000, 0, 0, 1);
      step(0, 4'b0000, 0, 0, 1);

      // Fill to two entries, check gating, then drain in order.
      step(0, 4'b1010, 3, 1, 0);
      step(0, 4'b0010, 1, 1, 0);
      step(0, 4'b0001, 0, 0, 0);
      step(0, 4'b0001, 0, 0, 1);
      step(0, 4'b0001, 0, 0, 1);
      step(0, 4'b0000, 0, 0, 1);
      step(0, 4'b0000, 0, 0, 1);

      // All requesters valid behind a rotating arbiter: one per cycle.
      for (int i = 0; i < 16; i++) step(0, 4'b1111, 0, 0, 1, 1);
      step(0, 4'b0000, 0, 0, 1);
      step(0, 4'b0000, 0, 0, 1);

      // Grant to an idle requester: sticky error.
      step(0, 4'b0010, 0, 1, 1);
      for (int i = 0; i < 11; i++) step(0, 4'b0000, 0, 0, 1);

      // Reset with a full buffer.
      step(0, 4'b0011, 0, 1, 0);
      step(0, 4'b0011, 1, 1, 0);
      step(1, 4'b0101, 0, 0, 0);
      step(0, 4'b0101, 0, 0, 0);
      step(0, 4'b0000, 0, 0, 1);

      // Stall with a full buffer; late grants must be refused.
      step(0, 4'b1100, 2, 1, 0);
      step(0, 4'b1000, 3, 1, 0);
      step(0, 4'b0110, 1, 0, 0);
      step(0, 4'b0110, 1, 0, 0);
      step(0, 4'b0110, 1, 0, 0);
      step(0, 4'b0110, 1, 1, 0);
      step(0, 4'b0110, 2, 1, 0);
      step(0, 4'b0000, 0, 0, 1);
      step(0, 4'b0000, 0, 0, 1);
      step(1, 4'b0000, 0, 0, 1);

      // Randomized traffic, mostly legal grants, occasional resets.
      for (int i = 0; i < 600; i++) begin
         rv = 4'($urandom);
         g  = $urandom_range(0, N - 1);
         if (rv != 0 && ($urandom % 16) != 0) begin
            while (!rv[g]) g = $urandom_range(0, N - 1);
         end
         step(($urandom % 64) == 0, rv, g, ($urandom % 4) != 0,
              ($urandom % 10) < 7, i >= 300 && ($urandom % 2) == 0);
      end

      for (int i = 0; i < 4; i++) step(0, 4'b0000, 0, 0, 1);
      @(posedge clk);
      commit();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
